// File: rtl/segmented_adder_sub.sv
// segmented_adder_sub: multi-cycle add/subtract, one SEG-bit segment per clock, LSB first
// Ports: clk, rst_n (async active-low); start/op/a/b/cin request (latched at accept);
//        busy, done (1-cycle pulse), s, carry_out, overflow, zero (held until next completion)
module segmented_adder_sub #(
  parameter int WIDTH = 16,
  parameter int SEG = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int NSEG = WIDTH / SEG;
  localparam int IW = $clog2(NSEG + 1);
  localparam logic [IW-1:0] LAST = IW'(NSEG - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] a_r, b_r, work, work_nx;
  logic carry_r, accept, last;
  logic [SEG:0] seg_sum;
  assign accept = state == IDLE && start;
  assign last = state == RUN && idx == LAST;
  assign busy = state == RUN;
  // operands shift right each cycle so the active segment is always the low SEG bits
  assign seg_sum = {1'b0, a_r[SEG-1:0]} + {1'b0, b_r[SEG-1:0]} + {{SEG{1'b0}}, carry_r};
  // result fills from the top; after NSEG shifts the first segment lands at bit 0
  assign work_nx = (work >> SEG) | (WIDTH'(seg_sum[SEG-1:0]) << (WIDTH - SEG));
  always_comb state_nx = accept ? RUN : last ? IDLE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      a_r <= '0;
      b_r <= '0;
      work <= '0;
      carry_r <= 1'b0;
      done <= 1'b0;
      s <= '0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        a_r <= a;
        b_r <= op ? ~b : b;
        carry_r <= op | cin;
        idx <= '0;
        work <= '0;
      end else if (busy) begin
        a_r <= a_r >> SEG;
        b_r <= b_r >> SEG;
        carry_r <= seg_sum[SEG];
        idx <= idx + 1'b1;
        work <= work_nx;
        if (last) begin
          s <= work_nx;
          carry_out <= seg_sum[SEG];
          // on the last segment bit SEG-1 of the shifted operands is the original MSB
          overflow <= (a_r[SEG-1] ~^ b_r[SEG-1]) & (a_r[SEG-1] ^ seg_sum[SEG-1]);
          zero <= work_nx == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_segmented_adder_sub.sv
// tb_segmented_adder_sub: directed vectors, handshake/reset sequences and parameter sweeps
module tb_segmented_adder_sub;
  logic clk = 0;
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic rst_n, start, op, cin, busy, done, cout, ovf, zero;
  logic [15:0] a, b, s;
  segmented_adder_sub #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .s(s), .carry_out(cout), .overflow(ovf), .zero(zero)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    while (lat < 40 && !done) begin
      @(posedge clk);
      #1 lat++;
      if (busy) bcnt++;
    end
  endtask
  task automatic run_op(input logic o, input logic [15:0] x, input logic [15:0] y, input logic ci,
                        output int lat, output int bcnt);
    int bc;
    @(negedge clk);
    op = o; a = x; b = y; cin = ci; start = 1;
    @(posedge clk);
    #1 start = 0;
    bc = busy;
    wait_done(lat, bcnt);
    bcnt += bc;
  endtask
  typedef struct {
    logic op; logic [15:0] a, b; logic cin;
    logic [15:0] s; logic c, v, z;
  } vec_t;
  vec_t vt[8];
  genvar g;
  for (g = 0; g < 3; g++) begin : sw
    localparam int W = (g == 2) ? 8 : 16;
    localparam int S = (g == 0) ? 16 : ((g == 1) ? 1 : 2);
    logic r, st, o, ci, bz, dn, co, ov, zr, f = 0;
    logic [W-1:0] x, y, sm;
    segmented_adder_sub #(.WIDTH(W), .SEG(S)) u (
      .clk(clk), .rst_n(r), .start(st), .op(o), .a(x), .b(y), .cin(ci),
      .busy(bz), .done(dn), .s(sm), .carry_out(co), .overflow(ov), .zero(zr)
    );
    initial begin
      logic [W:0] rv;
      logic [W-1:0] yb;
      logic v;
      int lat;
      r = 0; st = 0; o = 0; ci = 0; x = 0; y = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) r = 1;
      for (int n = 0; n < 1000; n++) begin
        @(negedge clk);
        x = W'($urandom); y = W'($urandom); o = 1'($urandom); ci = 1'($urandom); st = 1;
        @(posedge clk);
        #1 st = 0;
        lat = 0;
        while (lat < W + 4 && !dn) begin
          @(posedge clk);
          #1 lat++;
        end
        yb = o ? ~y : y;
        rv = {1'b0, x} + {1'b0, yb} + (W + 1)'(o | ci);
        v = (x[W-1] == yb[W-1]) && (rv[W-1] != x[W-1]);
        chk($sformatf("sweep%0d latency", g), lat, W / S);
        chk($sformatf("sweep%0d {c,v,z,s}", g), 32'({co, ov, zr, sm}),
            32'({rv[W], v, rv[W-1:0] == '0, rv[W-1:0]}));
      end
      f = 1;
    end
  end
  initial begin
    int lat, bc, np, lt, t, dsum;
    vt[0] = '{0, 16'h1234, 16'h0FFF, 0, 16'h2233, 0, 0, 0};
    vt[1] = '{0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 1};
    vt[2] = '{0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, 0};
    vt[3] = '{0, 16'h0000, 16'h0000, 1, 16'h0001, 0, 0, 0};
    vt[4] = '{1, 16'h0005, 16'h0007, 0, 16'hFFFE, 0, 0, 0};
    vt[5] = '{1, 16'h8000, 16'h0001, 0, 16'h7FFF, 1, 1, 0};
    vt[6] = '{1, 16'h0005, 16'h0007, 1, 16'hFFFE, 0, 0, 0};
    vt[7] = '{1, 16'h1234, 16'h1234, 0, 16'h0000, 1, 0, 1};
    rst_n = 0; start = 0; op = 0; cin = 0; a = 0; b = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset s", s, 0);
    chk("reset carry", cout, 0);
    chk("reset ovf", ovf, 0);
    chk("reset zero", zero, 0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].cin, lat, bc);
      chk($sformatf("vec%0d latency", i), lat, 4);
      chk($sformatf("vec%0d busy cycles", i), bc, 4);
      chk($sformatf("vec%0d s", i), s, vt[i].s);
      chk($sformatf("vec%0d carry", i), cout, vt[i].c);
      chk($sformatf("vec%0d ovf", i), ovf, vt[i].v);
      chk($sformatf("vec%0d zero", i), zero, vt[i].z);
      @(posedge clk);
      #1 chk($sformatf("vec%0d done width", i), done, 0);
    end
    // operand/op changes and a start pulse mid-RUN must not disturb the result
    @(negedge clk);
    op = 0; a = 16'h1234; b = 16'h0FFF; cin = 0; start = 1;
    @(posedge clk);
    #1 start = 0;
    @(posedge clk);
    #1 a = 16'hFFFF; b = 16'hFFFF; op = 1; start = 1;
    @(posedge clk);
    #1 start = 0;
    wait_done(lat, bc);
    chk("midrun s", s, 16'h2233);
    chk("midrun latency", lat, 2);
    dsum = 0;
    repeat (8) begin
      @(posedge clk);
      #1 dsum += done;
    end
    chk("midrun extra done", dsum, 0);
    // start held high: accept in each done cycle
    @(negedge clk);
    op = 0; a = 16'h0001; b = 16'h0002; cin = 0; start = 1;
    np = 0; lt = -1; t = 0;
    for (int i = 0; i < 40 && np < 3; i++) begin
      @(posedge clk);
      #1 t++;
      if (done) begin
        if (lt >= 0) chk("b2b spacing", t - lt, 5);
        lt = t;
        np++;
        chk("b2b s", s, 16'h0003);
      end else if (np > 0) chk("b2b s hold", s, 16'h0003);
    end
    start = 0;
    chk("b2b pulses", np, 3);
    // reset during the second RUN cycle
    @(negedge clk);
    op = 0; a = 16'h1111; b = 16'h1111; start = 1;
    @(posedge clk);
    #1 start = 0;
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort s", s, 0);
    chk("abort carry", cout, 0);
    chk("abort ovf", ovf, 0);
    chk("abort zero", zero, 0);
    dsum = 0;
    repeat (5) begin
      @(posedge clk);
      #1 dsum += done;
    end
    chk("abort no done", dsum, 0);
    @(negedge clk) rst_n = 1;
    run_op(0, 16'h00FF, 16'h0001, 0, lat, bc);
    chk("post-reset s", s, 16'h0100);
    chk("post-reset latency", lat, 4);
    for (int i = 0; i < 40000 && !(sw[0].f && sw[1].f && sw[2].f); i++) @(posedge clk);
    chk("sweeps finished", {sw[0].f, sw[1].f, sw[2].f}, 3'b111);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/segmented_adder_sub.md
Name: segmented_adder_sub

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the fixed 4-bit ripple adder.
- Splits WIDTH-bit operands into SEG-bit segments and processes one segment per clock, LSB first.
- A registered carry links the segments, trading latency for a short carry chain.
- Uses a start/busy/done handshake and reports carry, signed overflow and zero flags.
- Serves as the arithmetic unit for datapaths where one wide carry chain per cycle is too slow.

Parameters:
- WIDTH, 16: operand and result width in bits; must be a multiple of SEG.
- SEG, 4: bits processed per cycle; 1 <= SEG <= WIDTH.
- NSEG, WIDTH/SEG: derived localparam; number of RUN cycles.

Ports:
- clk  input  1  single clock; rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while busy=0.
- op  input  1  0 = add (a+b+cin); 1 = subtract (a-b, computed as a + ~b + 1; cin ignored).
- a  input  WIDTH  operand A; latched at accept.
- b  input  WIDTH  operand B; latched at accept.
- cin  input  1  carry-in for add; latched at accept.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; result valid.
- s  output  WIDTH  result; updated only at completion.
- carry_out  output  1  carry out of the MSB. For subtract, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  high when s == 0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, segment index=0, internal registers=0; busy, done, s, carry_out, overflow and zero all 0. Deassertion is not synchronised inside the block.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - No separate DONE state; done is a registered pulse.
- Accept: rising edge with state=IDLE and start=1 (edge k).
  - Latch a, b' (b or ~b per op), and initial carry (cin for add, 1 for sub).
  - Clear segment index and working sum; go to RUN.
  - busy=1 from edge k.
- RUN, one segment per edge:
  - At edge k+i (i = 1..NSEG), segment i-1 is computed as slice(a) + slice(b') + carry_reg.
  - The SEG-bit sum goes into the working register; carry_reg takes the segment carry out.
- Completion at edge k+NSEG:
  - s <= full working result; carry_out <= final carry.
  - overflow <= a[MSB] ~^ b'[MSB] AND (a[MSB] ^ s[MSB]).
  - zero <= (s == 0); done <= 1; busy <= 0; state <= IDLE.
- Latency: done is high in the cycle after edge k+NSEG, i.e. NSEG cycles after accept. done lasts exactly one cycle.
- Result hold: s and flags hold their values until the next completion. They never show partial sums.
- start while busy=1 is ignored and not queued. Operand or op changes during RUN have no effect.
- Back-to-back: start held high gives the next accept at edge k+NSEG+1, so throughput is one op per NSEG+1 cycles. A start in the done cycle is accepted.
- SEG == WIDTH: NSEG=1; done is asserted one cycle after accept.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Reset mid-RUN aborts the operation. All outputs clear immediately, no done is issued, and the next accept behaves normally.

Test Plan:
- WIDTH=16, SEG=4: add 0x1234 + 0x0FFF, cin=0 -> s=0x2233, carry_out=0, overflow=0, zero=0. done exactly 4 cycles after accept; busy high for those 4 cycles.
- Add 0xFFFF + 0x0001, cin=0 -> s=0x0000, carry_out=1, zero=1, overflow=0. Add 0x7FFF + 0x0001 -> s=0x8000, overflow=1, carry_out=0. Add 0x0000 + 0x0000, cin=1 -> s=0x0001.
- Subtract 0x0005 - 0x0007 -> s=0xFFFE, carry_out=0, overflow=0. Subtract 0x8000 - 0x0001 -> s=0x7FFF, carry_out=1, overflow=1. With cin=1 on a subtract -> result unchanged.
- Handshake, part 1: change a/b/op while busy and pulse start mid-RUN -> original result returned, no extra done.
- Handshake, part 2: hold start high with fixed operands -> done pulses spaced NSEG+1 cycles apart. s stays stable between pulses.
- Reset: assert rst_n=0 during the 2nd RUN cycle -> all outputs 0 immediately, no done. After release, add 0x00FF + 0x0001 -> s=0x0100.
- Parameter sweep with SEG=16, SEG=1 and WIDTH=8/SEG=2: 1000 random add/sub ops compared against a behavioural model (s, carry_out, overflow, zero). Latency must equal WIDTH/SEG cycles (1 and 16 at WIDTH=16).
